// File: rtl/exception_ctrl_pkg.sv
// rtl/exception_ctrl_pkg.sv - shared exception codes, CP0 addresses and flag positions
package exception_ctrl_pkg;

  localparam int FLAG_W = 10;

  localparam int FLG_ADEL_IF   = 0;
  localparam int FLG_RI        = 1;
  localparam int FLG_SYSCALL   = 2;
  localparam int FLG_BRK       = 3;
  localparam int FLG_OV        = 4;
  localparam int FLG_ADEL_MEM  = 5;
  localparam int FLG_ADES      = 6;
  localparam int FLG_TLBMISS_L = 7;
  localparam int FLG_TLBMISS_S = 8;
  localparam int FLG_ERET      = 9;

  localparam logic [4:0] EXC_NONE = 5'h00;
  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [4:0] CP0_EBASE  = 5'd15;

  localparam logic [31:0] VEC_OFFSET = 32'h0000_0180;

  typedef enum logic [1:0] {BVA_NONE, BVA_PC, BVA_DATA} bva_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
    logic       tlbmiss;
    logic       load;
    logic       is_eret;
    logic       is_int;
    bva_sel_e   bva_sel;
  } exc_dec_t;

  typedef enum logic {ST_IDLE, ST_SHADOW} state_e;

endpackage

// File: rtl/exception_ctrl_exc_priority_enc.sv
// rtl/exception_ctrl_exc_priority_enc.sv - picks the single highest-priority exception source
module exc_priority_enc
  import exception_ctrl_pkg::*;
(
  input  logic              int_i,
  input  logic [FLAG_W-1:0] flags_i,
  output exc_dec_t          dec_o
);

  always_comb begin
    dec_o         = '0;
    dec_o.bva_sel = BVA_NONE;
    dec_o.valid   = 1'b1;
    if (int_i) begin
      dec_o.code   = EXC_INT;
      dec_o.is_int = 1'b1;
    end else if (flags_i[FLG_ADEL_IF]) begin
      dec_o.code    = EXC_ADEL;
      dec_o.bva_sel = BVA_PC;
    end else if (flags_i[FLG_RI]) begin
      dec_o.code = EXC_RI;
    end else if (flags_i[FLG_SYSCALL]) begin
      dec_o.code = EXC_SYS;
    end else if (flags_i[FLG_BRK]) begin
      dec_o.code = EXC_BP;
    end else if (flags_i[FLG_OV]) begin
      dec_o.code = EXC_OV;
    end else if (flags_i[FLG_ADEL_MEM]) begin
      dec_o.code    = EXC_ADEL;
      dec_o.bva_sel = BVA_DATA;
    end else if (flags_i[FLG_ADES]) begin
      dec_o.code    = EXC_ADES;
      dec_o.bva_sel = BVA_DATA;
    end else if (flags_i[FLG_TLBMISS_L] || flags_i[FLG_TLBMISS_S]) begin
      // TLB refill is signalled by its own flag; the CP0 code stays zero
      dec_o.code    = EXC_NONE;
      dec_o.tlbmiss = 1'b1;
      dec_o.load    = flags_i[FLG_TLBMISS_L];
      dec_o.bva_sel = BVA_DATA;
    end else if (flags_i[FLG_ERET]) begin
      dec_o.code    = EXC_ERET;
      dec_o.is_eret = 1'b1;
    end else begin
      dec_o.valid = 1'b0;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - MEM-stage exception arbiter, CP0 port driver and redirect unit
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter int SHADOW_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  input  logic              stall_i,
  input  logic [31:0]       mem_pc_i,
  input  logic              mem_in_delay_slot_i,
  input  logic [31:0]       mem_badvaddr_i,
  input  logic [FLAG_W-1:0] exc_flags_i,
  input  logic [31:0]       cp0_status_i,
  input  logic [31:0]       cp0_cause_i,
  input  logic [31:0]       cp0_epc_i,
  input  logic [31:0]       cp0_ebase_i,
  input  logic              wb_cp0_we_i,
  input  logic [4:0]        wb_cp0_addr_i,
  input  logic [31:0]       wb_cp0_data_i,
  output logic [31:0]       exc_type_o,
  output logic [31:0]       exc_addr_o,
  output logic              in_delay_slot_o,
  output logic [31:0]       badvaddr_o,
  output logic              tlbmiss_o,
  output logic              load_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic [15:0]       exc_count_o
);

  localparam logic [2:0] SHADOW_LAST = 3'(SHADOW_CYCLES - 1);

  state_e      r_state;
  logic [2:0]  r_shadow_cnt;
  logic        r_int_pend;
  logic [15:0] r_exc_count;

  logic [31:0] w_status, w_cause, w_epc, w_ebase;
  logic        w_int_req, w_can_report, w_report;
  exc_dec_t    w_dec;

  // Forward an mtc0 still sitting in WB so the decision uses the value CP0 is about to hold
  assign w_status = (wb_cp0_we_i && wb_cp0_addr_i == CP0_STATUS) ? wb_cp0_data_i : cp0_status_i;
  assign w_epc    = (wb_cp0_we_i && wb_cp0_addr_i == CP0_EPC)    ? wb_cp0_data_i : cp0_epc_i;
  assign w_ebase  = (wb_cp0_we_i && wb_cp0_addr_i == CP0_EBASE)  ? wb_cp0_data_i : cp0_ebase_i;
  assign w_cause  = (wb_cp0_we_i && wb_cp0_addr_i == CP0_CAUSE)
                  ? {cp0_cause_i[31:10], wb_cp0_data_i[9:8], cp0_cause_i[7:0]} : cp0_cause_i;

  assign w_int_req    = w_status[0] & ~w_status[1] & |(w_cause[15:8] & w_status[15:8]);
  assign w_can_report = (r_state == ST_IDLE) && mem_valid_i && !stall_i;
  assign w_report     = w_can_report && w_dec.valid && !rst;

  exc_priority_enc u_enc (
    .int_i   (w_int_req | r_int_pend),
    .flags_i (exc_flags_i),
    .dec_o   (w_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shadow_cnt <= '0;
      r_int_pend   <= 1'b0;
      r_exc_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_report) begin
            r_state      <= ST_SHADOW;
            r_shadow_cnt <= '0;
          end
        end
        ST_SHADOW: begin
          if (r_shadow_cnt == SHADOW_LAST) begin
            r_state      <= ST_IDLE;
            r_shadow_cnt <= '0;
          end else begin
            r_shadow_cnt <= r_shadow_cnt + 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if ((w_report && w_dec.is_int) || !w_status[0] || w_status[1])
        r_int_pend <= 1'b0;
      else if (w_int_req && !w_can_report)
        r_int_pend <= 1'b1;

      if (w_report && !w_dec.is_eret && r_exc_count != 16'hFFFF)
        r_exc_count <= r_exc_count + 16'd1;
    end
  end

  always_comb begin
    exc_type_o      = '0;
    exc_addr_o      = '0;
    in_delay_slot_o = 1'b0;
    badvaddr_o      = '0;
    tlbmiss_o       = 1'b0;
    load_o          = 1'b0;
    flush_o         = 1'b0;
    new_pc_o        = '0;
    if (w_report) begin
      exc_type_o      = {27'd0, w_dec.code};
      exc_addr_o      = mem_pc_i;
      in_delay_slot_o = mem_in_delay_slot_i;
      tlbmiss_o       = w_dec.tlbmiss;
      load_o          = w_dec.load;
      flush_o         = 1'b1;
      case (w_dec.bva_sel)
        BVA_PC:   badvaddr_o = mem_pc_i;
        BVA_DATA: badvaddr_o = mem_badvaddr_i;
        default:  badvaddr_o = '0;
      endcase
      if (w_dec.is_eret)
        new_pc_o = w_epc;
      else if (w_dec.tlbmiss && !w_status[1])
        new_pc_o = w_ebase;
      else
        new_pc_o = w_ebase + VEC_OFFSET;
    end
  end

  assign exc_count_o = rst ? 16'd0 : r_exc_count;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed self-checking bench for exception_ctrl
`timescale 1ns/1ps
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i, stall_i, mem_in_delay_slot_i;
  logic [31:0] mem_pc_i, mem_badvaddr_i;
  logic [9:0]  exc_flags_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_addr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] exc_type_o, exc_addr_o, badvaddr_o, new_pc_o;
  logic        in_delay_slot_o, tlbmiss_o, load_o, flush_o;
  logic [15:0] exc_count_o;

  int total = 0;
  int bad   = 0;
  logic done = 1'b0;

  localparam logic [9:0] F_ADEL_IF = 10'h001;
  localparam logic [9:0] F_RI      = 10'h002;
  localparam logic [9:0] F_SYS     = 10'h004;
  localparam logic [9:0] F_OV      = 10'h010;
  localparam logic [9:0] F_ADES    = 10'h040;
  localparam logic [9:0] F_TLBL    = 10'h080;
  localparam logic [9:0] F_ERET    = 10'h200;

  always #5 clk = ~clk;

  exception_ctrl #(.SHADOW_CYCLES(1)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_valid_i         (mem_valid_i),
    .stall_i             (stall_i),
    .mem_pc_i            (mem_pc_i),
    .mem_in_delay_slot_i (mem_in_delay_slot_i),
    .mem_badvaddr_i      (mem_badvaddr_i),
    .exc_flags_i         (exc_flags_i),
    .cp0_status_i        (cp0_status_i),
    .cp0_cause_i         (cp0_cause_i),
    .cp0_epc_i           (cp0_epc_i),
    .cp0_ebase_i         (cp0_ebase_i),
    .wb_cp0_we_i         (wb_cp0_we_i),
    .wb_cp0_addr_i       (wb_cp0_addr_i),
    .wb_cp0_data_i       (wb_cp0_data_i),
    .exc_type_o          (exc_type_o),
    .exc_addr_o          (exc_addr_o),
    .in_delay_slot_o     (in_delay_slot_o),
    .badvaddr_o          (badvaddr_o),
    .tlbmiss_o           (tlbmiss_o),
    .load_o              (load_o),
    .flush_o             (flush_o),
    .new_pc_o            (new_pc_o),
    .exc_count_o         (exc_count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    if (!done) begin
      bad++;
      $error("FAIL timeout waiting for test completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; mem_valid_i = 1'b1; stall_i = 1'b0; mem_in_delay_slot_i = 1'b0;
    mem_pc_i = 32'h0; mem_badvaddr_i = 32'h0; exc_flags_i = 10'h3ff;
    cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0; cp0_ebase_i = 32'h8000_0000;
    wb_cp0_we_i = 1'b0; wb_cp0_addr_i = 5'd0; wb_cp0_data_i = 32'h0;

    next_cycle(); #1;
    check("rst_type", exc_type_o, 32'h0);
    check("rst_flush", flush_o, 1'b0);
    check("rst_newpc", new_pc_o, 32'h0);
    check("rst_tlb", tlbmiss_o, 1'b0);
    check("rst_load", load_o, 1'b0);
    check("rst_bva", badvaddr_o, 32'h0);
    check("rst_addr", exc_addr_o, 32'h0);
    check("rst_ds", in_delay_slot_o, 1'b0);
    next_cycle(); #1;
    check("rst_count", exc_count_o, 16'h0);

    // syscall in a delay slot
    next_cycle();
    rst = 1'b0; exc_flags_i = F_SYS; mem_pc_i = 32'h8000_1000; mem_in_delay_slot_i = 1'b1;
    #1;
    check("sys_type", exc_type_o, 32'h8);
    check("sys_addr", exc_addr_o, 32'h8000_1000);
    check("sys_ds", in_delay_slot_o, 1'b1);
    check("sys_flush", flush_o, 1'b1);
    check("sys_newpc", new_pc_o, 32'h8000_0180);
    check("sys_bva", badvaddr_o, 32'h0);
    next_cycle(); #1;
    check("shadow_type", exc_type_o, 32'h0);
    check("shadow_flush", flush_o, 1'b0);
    check("count1", exc_count_o, 16'd1);

    // ri + ov + ades together
    next_cycle();
    exc_flags_i = F_RI | F_OV | F_ADES; mem_in_delay_slot_i = 1'b0; mem_badvaddr_i = 32'h1234;
    #1;
    check("multi_type", exc_type_o, 32'ha);
    check("multi_bva", badvaddr_o, 32'h0);
    next_cycle(); exc_flags_i = 10'h0; #1;
    check("count2", exc_count_o, 16'd2);

    // TLB load miss, EXL=0 then EXL=1
    next_cycle();
    exc_flags_i = F_TLBL; mem_badvaddr_i = 32'h0040_3000;
    #1;
    check("tlb_miss", tlbmiss_o, 1'b1);
    check("tlb_load", load_o, 1'b1);
    check("tlb_type", exc_type_o, 32'h0);
    check("tlb_newpc", new_pc_o, 32'h8000_0000);
    check("tlb_bva", badvaddr_o, 32'h0040_3000);
    check("tlb_flush", flush_o, 1'b1);
    next_cycle(); exc_flags_i = 10'h0;
    next_cycle();
    exc_flags_i = F_TLBL; cp0_status_i = 32'h2;
    #1;
    check("tlb_exl_newpc", new_pc_o, 32'h8000_0180);
    check("tlb_exl_miss", tlbmiss_o, 1'b1);
    next_cycle(); exc_flags_i = 10'h0; cp0_status_i = 32'h0; #1;
    check("count4", exc_count_o, 16'd4);

    // fetch address error reports the PC as bad address
    next_cycle();
    exc_flags_i = F_ADEL_IF; mem_pc_i = 32'h8000_3001;
    #1;
    check("adelif_type", exc_type_o, 32'h4);
    check("adelif_bva", badvaddr_o, 32'h8000_3001);
    next_cycle(); exc_flags_i = 10'h0;

    // stall blocks the report
    next_cycle();
    exc_flags_i = F_SYS; stall_i = 1'b1;
    #1;
    check("stall_flush", flush_o, 1'b0);
    next_cycle(); stall_i = 1'b0; #1;
    check("unstall_type", exc_type_o, 32'h8);
    next_cycle(); exc_flags_i = 10'h0; #1;
    check("count6", exc_count_o, 16'd6);

    // interrupt arriving during bubbles is latched
    cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400; mem_valid_i = 1'b0;
    mem_pc_i = 32'h8000_2000;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      check("bubble_flush", flush_o, 1'b0);
    end
    next_cycle();
    cp0_cause_i = 32'h0; mem_valid_i = 1'b1;
    #1;
    check("int_type", exc_type_o, 32'h1);
    check("int_addr", exc_addr_o, 32'h8000_2000);
    check("int_newpc", new_pc_o, 32'h8000_0180);
    next_cycle(); #1;
    check("count7", exc_count_o, 16'd7);
    next_cycle(); #1;
    check("pend_cleared", flush_o, 1'b0);
    cp0_status_i = 32'h0;

    // ERET with EPC forwarded from WB
    next_cycle();
    exc_flags_i = F_ERET; cp0_epc_i = 32'h0;
    wb_cp0_we_i = 1'b1; wb_cp0_addr_i = 5'd14; wb_cp0_data_i = 32'h8000_4000;
    #1;
    check("eret_type", exc_type_o, 32'he);
    check("eret_newpc", new_pc_o, 32'h8000_4000);
    check("eret_flush", flush_o, 1'b1);
    next_cycle(); exc_flags_i = 10'h0; wb_cp0_we_i = 1'b0; #1;
    check("eret_count", exc_count_o, 16'd7);

    // interrupt beats ERET
    next_cycle();
    cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400; exc_flags_i = F_ERET;
    #1;
    check("int_eret_type", exc_type_o, 32'h1);
    check("int_eret_newpc", new_pc_o, 32'h8000_0180);
    next_cycle(); cp0_status_i = 32'h0; cp0_cause_i = 32'h0; exc_flags_i = 10'h0; #1;
    check("count8", exc_count_o, 16'd8);

    // WB write to CAUSE forwards only the software-interrupt bits
    next_cycle();
    cp0_status_i = 32'h0000_0101;
    wb_cp0_we_i = 1'b1; wb_cp0_addr_i = 5'd13; wb_cp0_data_i = 32'h0000_0100;
    #1;
    check("swint_type", exc_type_o, 32'h1);
    next_cycle(); wb_cp0_we_i = 1'b0; cp0_status_i = 32'h0;

    // reset during SHADOW
    next_cycle();
    exc_flags_i = F_SYS;
    #1;
    check("pre_rst_type", exc_type_o, 32'h8);
    next_cycle(); rst = 1'b1; #1;
    check("shadow_rst_flush", flush_o, 1'b0);
    check("shadow_rst_count", exc_count_o, 16'd0);
    next_cycle(); rst = 1'b0; #1;
    check("post_rst_type", exc_type_o, 32'h8);
    check("post_rst_count", exc_count_o, 16'd0);
    next_cycle(); exc_flags_i = 10'h0; #1;
    check("post_rst_count1", exc_count_o, 16'd1);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
